ifu: RTL and testbench

Instruction fetch unit for the single-issue NPC core, directly upstream of the decode stage. Holds the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a request/response handshake, and presents `inst_id`/`pc_id` to decode through a one-entry valid/ready output buffer. Accepts a PC redirect from jump resolution and discards any in-flight fetch made stale by it.

---
 rtl/ifu_pkg.sv | 12 +
 rtl/defines.svh | 8 +
 rtl/ifu.sv | 113 +++++++++++
 tb/tb_ifu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} ifu_state_e;

  localparam int INST_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/defines.svh
`ifndef DEFINES_SVH
`define DEFINES_SVH

`define INST_ADDR_BUS 31:0
`define INST_DATA_BUS 31:0
`define ZERO_WORD     32'h0000_0000

`endif

// File: rtl/ifu.sv
// Instruction fetch: one outstanding imem request, one-entry output buffer to decode.
// Request->inst_valid in 2 cycles (3-cycle peak cadence); stalls in S_OUT until decode takes the instruction.
`include "defines.svh"

module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [`INST_DATA_BUS] inst_id,
  output logic [`INST_ADDR_BUS] pc_id,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           fetch_cnt
);

  ifu_state_e            r_state;
  ifu_state_e            w_state_nxt;
  logic [31:0]           r_pc;
  logic                  r_kill;
  logic [`INST_DATA_BUS] r_inst;
  logic [`INST_ADDR_BUS] r_pc_id;
  logic [31:0]           r_cnt;

  logic w_req_acc;
  logic w_rsp_in_wait;
  logic w_out_hs;
  logic w_capture;

  assign w_req_acc     = (r_state == S_REQ) && imem_req_ready;
  assign w_rsp_in_wait = (r_state == S_WAIT) && imem_rsp_valid;
  assign w_out_hs      = (r_state == S_OUT) && inst_ready;
  assign w_capture     = w_rsp_in_wait && !r_kill && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (imem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) w_state_nxt = w_capture ? S_OUT : S_REQ;
      S_OUT:   if (inst_ready || redirect_valid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (r_state)
      S_REQ:   imem_req_valid = 1'b1;
      S_OUT:   inst_valid     = 1'b1;
      default: ;
    endcase
  end

  // Redirect wins over the sequential increment, even when the handshake completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= word_align(RESET_PC);
      r_kill  <= 1'b0;
      r_inst  <= `ZERO_WORD;
      r_pc_id <= `ZERO_WORD;
      r_cnt   <= 32'd0;
    end else begin
      if (redirect_valid) begin
        r_pc <= word_align(redirect_pc);
      end else if (w_out_hs) begin
        r_pc <= r_pc + 32'(INST_BYTES);
      end

      // A redirect while a request is in flight (or being accepted) makes its response stale.
      if (w_rsp_in_wait) begin
        r_kill <= 1'b0;
      end else if (redirect_valid && (w_req_acc || r_state == S_WAIT)) begin
        r_kill <= 1'b1;
      end

      if (w_capture) begin
        r_inst  <= imem_rsp_data;
        r_pc_id <= r_pc;
      end

      if (w_out_hs) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign imem_req_addr = r_pc;
  assign inst_id       = r_inst;
  assign pc_id         = r_pc_id;
  assign fetch_cnt     = r_cnt;

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_state == S_WAIT));

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: expected fetch addresses and delivered instructions go into queues
// that an independent negedge monitor drains, plus point checks of state between steps.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_req_q[$];
  logic [63:0] exp_out_q[$];

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_id        (inst_id),
    .pc_id          (pc_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every request and delivery handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
        end else begin
          logic [31:0] ea;
          ea = exp_req_q.pop_front();
          if (imem_req_addr !== ea) begin
            errors++;
            $display("FAIL req_addr: got %h expected %h", imem_req_addr, ea);
          end
        end
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_out_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got inst %h pc %h expected no delivery", inst_id, pc_id);
        end else begin
          logic [63:0] eo;
          eo = exp_out_q.pop_front();
          if ({inst_id, pc_id} !== eo) begin
            errors++;
            $display("FAIL out_data: got inst %h pc %h expected inst %h pc %h",
                     inst_id, pc_id, eo[63:32], eo[31:0]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr);
    exp_req_q.push_back(addr);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] pc, input bit deliver);
    if (deliver) exp_out_q.push_back({data, pc});
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    cyc();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic take();
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_id", inst_id, 32'd0);
    chk("rst_pc_id", pc_id, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);

    // Basic fetch at minimum latency
    issue(32'h8000_0000);
    respond(32'h0000_0413, 32'h8000_0000, 1'b1);
    chk("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_pc_id", pc_id, 32'h8000_0000);
    chk("t1_no_req_in_out", {31'd0, imem_req_valid}, 32'd0);
    take();
    chk("t1_fetch_cnt", fetch_cnt, 32'd1);
    chk("t1_next_addr", imem_req_addr, 32'h8000_0004);

    // Decode backpressure
    issue(32'h8000_0004);
    respond(32'h0010_0093, 32'h8000_0004, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("t2_inst_id", inst_id, 32'h0010_0093);
      chk("t2_pc_id", pc_id, 32'h8000_0004);
      chk("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("t2_fetch_cnt", fetch_cnt, 32'd1);
      cyc();
    end
    take();
    chk("t2_fetch_cnt_after", fetch_cnt, 32'd2);

    // Redirect while waiting; late response must be dropped
    issue(32'h8000_0008);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t3_waiting", {31'd0, imem_req_valid}, 32'd0);
    respond(32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("t3_dropped", {31'd0, inst_valid}, 32'd0);
    chk("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t3_next_addr", imem_req_addr, 32'h8000_0100);

    // Redirect coincident with the response
    issue(32'h8000_0100);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    respond(32'h1111_1111, 32'h0, 1'b0);
    redirect_valid = 1'b0;
    chk("t4_dropped", {31'd0, inst_valid}, 32'd0);
    chk("t4_next_addr", imem_req_addr, 32'h8000_0200);
    issue(32'h8000_0200);
    respond(32'h0020_0113, 32'h8000_0200, 1'b1);
    chk("t4_no_extra_wait", {31'd0, inst_valid}, 32'd1);

    // Redirect coincident with the decode handshake; low bits masked
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    take();
    redirect_valid = 1'b0;
    chk("t5_fetch_cnt", fetch_cnt, 32'd3);
    chk("t5_next_addr", imem_req_addr, 32'hFFFF_FFFC);

    // PC wrap
    issue(32'hFFFF_FFFC);
    respond(32'h0030_0193, 32'hFFFF_FFFC, 1'b1);
    take();
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    chk("t6_fetch_cnt", fetch_cnt, 32'd4);

    // Redirect in S_REQ without acceptance
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    cyc();
    redirect_valid = 1'b0;
    chk("t7_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t7_addr", imem_req_addr, 32'h8000_0400);

    // Redirect in the cycle the old address is accepted
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0800;
    issue(32'h8000_0400);
    redirect_valid = 1'b0;
    cyc();
    respond(32'hCAFE_F00D, 32'h0, 1'b0);
    chk("t8_dropped", {31'd0, inst_valid}, 32'd0);
    chk("t8_next_addr", imem_req_addr, 32'h8000_0800);

    // Redirect in S_OUT without inst_ready discards the buffer
    issue(32'h8000_0800);
    respond(32'h0040_0213, 32'h0, 1'b0);
    chk("t9_inst_valid", {31'd0, inst_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0C00;
    cyc();
    redirect_valid = 1'b0;
    chk("t9_buffer_dropped", {31'd0, inst_valid}, 32'd0);
    chk("t9_fetch_cnt", fetch_cnt, 32'd4);
    chk("t9_next_addr", imem_req_addr, 32'h8000_0C00);
    issue(32'h8000_0C00);
    respond(32'h0050_0293, 32'h8000_0C00, 1'b1);
    take();
    chk("t9_fetch_cnt_after", fetch_cnt, 32'd5);
    chk("t9_seq_addr", imem_req_addr, 32'h8000_0C04);

    // Reset while a request is outstanding
    issue(32'h8000_0C04);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t10_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t10_addr", imem_req_addr, 32'h8000_0000);
    chk("t10_fetch_cnt", fetch_cnt, 32'd0);
    chk("t10_inst_id", inst_id, 32'd0);
    cyc();

    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    chk("out_queue_drained", 32'(exp_out_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
